store_narrow_unit: RTL and testbench
====================================

Name: store_narrow_unit

Overview:
- Store-path counterpart of the load-path sign extender: narrows a 32-bit register value to a byte or halfword and stores it into a word-only data memory (no byte enables) via read-modify-write.
- Full-word stores are written directly.
- Reports a signed-narrowing overflow flag: the value does not round-trip through sign extension. Reports a misalignment/timeout error.
- Sits between the CPU MEM stage and the word-addressed data memory.

Parameters:
- RD_TIMEOUT, 16, max cycles to wait in WAIT_RD for mem_rd_valid before reporting an error (≥1)
- CNT_W, 5, width of timeout counter; must hold RD_TIMEOUT

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  store request valid
- req_ready  out  1  unit idle, can accept
- req_addr  in  32  byte address
- req_data  in  32  register value to store
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  valid with resp_valid: misaligned/illegal size/read timeout
- resp_ovf  out  1  valid with resp_valid: signed narrowing overflow
- mem_addr  out  32  word-aligned address ({req_addr[31:2],2'b00})
- mem_rd_en  out  1  one-cycle read strobe
- mem_rdata  in  32  read data, valid when mem_rd_valid
- mem_rd_valid  in  1  read data valid (latency ≥1 cycle)
- mem_wr_en  out  1  one-cycle write strobe
- mem_wdata  out  32  write data

Behaviour:
- Reset (rst_n=0 at rising edge): state=IDLE; req_ready=1; resp_valid, resp_err, resp_ovf, mem_rd_en, mem_wr_en=0; mem_addr, mem_wdata=0; timeout counter=0. Reset mid-operation aborts with no write and no response.
- Handshake: accept on req_valid&&req_ready at edge T. req_ready=1 only in IDLE. Address, data and size are latched at acceptance.
- Error check at acceptance: size 11, half with addr[0]=1, or word with addr[1:0]≠0 → ERR. ERR lasts one cycle (T+1): resp_valid=1, resp_err=1, resp_ovf=0, no memory access, then IDLE.
- Word path: IDLE→WRITE. At T+1: mem_wr_en=1, mem_wdata=req_data, resp_valid=1, resp_ovf=0. Then IDLE; next accept possible at edge T+2.
- Byte/half path: IDLE→READ (T+1: mem_rd_en=1) → WAIT_RD → WRITE → IDLE.
  - mem_rd_valid is sampled only in WAIT_RD.
  - On mem_rd_valid, mem_rdata is latched and merged. Little-endian lanes:
    - byte: lane addr[1:0], bits [8*lane+7 : 8*lane] replaced with req_data[7:0]
    - half: lane addr[1], bits [16*lane+15 : 16*lane] replaced with req_data[15:0]
    - other bits keep mem_rdata
  - Next cycle is WRITE: mem_wr_en=1 with merged data, resp_valid=1.
  - Minimum latency with 1-cycle memory: accept T, rd_en T+1, rd_valid T+2, write/resp T+3.
- Timeout: the counter clears on entering WAIT_RD and increments each WAIT_RD cycle without rd_valid. When it reaches RD_TIMEOUT: go to ERR, resp_err=1, no write. If rd_valid arrives in the same cycle the counter hits the limit, rd_valid wins.
- Overflow:
  - byte: resp_ovf = ~(req_data[31:7] all equal)
  - half: resp_ovf = ~(req_data[31:15] all equal)
  - word: resp_ovf = 0
  - The store still proceeds with the low bits; resp_ovf is informational only.
- mem_addr is held stable from READ through WRITE. Strobes are never asserted together.
- A req_valid held high during a busy state is ignored until req_ready.

Decomposition:
- Shared package:
  - size encoding constants SZ_BYTE/SZ_HALF/SZ_WORD
  - state enum {IDLE, READ, WAIT_RD, WRITE, ERR}
  - function fits_signed(data, size) for the overflow check
- Sub-module: store_lane_merge (combinational: rdata, wdata, addr[1:0], size → merged word). Reusable by a future load-extract unit test.

Test Plan:
- Word store addr=0x100, data=0xDEADBEEF → T+1 mem_wr_en=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, resp_valid=1, err=0, ovf=0.
- Byte store addr=0x203, data=0xFFFFFFFA, mem_rdata=0x11223344 (1-cycle latency) → rd at T+1, write at T+3, mem_wdata=0xFA223344, ovf=0.
- Half store addr=0x2, data=0x00008000, mem_rdata=0xAAAABBBB → mem_wdata=0x8000BBBB, resp_ovf=1. Repeat with data=0x00007FFF → ovf=0.
- Misaligned half addr=0x1 and word addr=0x6 → one-cycle resp_err=1, no mem_rd_en/mem_wr_en, req_ready back at T+2.
- Byte store with mem_rd_valid never asserted, RD_TIMEOUT=16 → resp_err=1 after 16 WAIT_RD cycles, no write. Separately, rd_valid on cycle 16 → normal write.
- rst_n=0 while in WAIT_RD → next cycle IDLE, req_ready=1, no write and no resp even if rd_valid arrives later.

Source files
------------

// File: rtl/store_narrow_unit_pkg.sv
// Shared types and helpers for the narrowing store unit and its lane merge.
// Holds the size encodings, FSM states, latched request payload and overflow check.
package store_narrow_unit_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned LANE_W = 2;

    localparam logic [SIZE_W-1:0] SZ_BYTE = 2'b00;
    localparam logic [SIZE_W-1:0] SZ_HALF = 2'b01;
    localparam logic [SIZE_W-1:0] SZ_WORD = 2'b10;
    localparam logic [SIZE_W-1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT_RD,
        WRITE,
        ERR
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SIZE_W-1:0] size;
        logic [LANE_W-1:0] lane;
    } req_t;

    // True when the narrowed value sign-extends back to the full register value.
    function automatic logic fits_signed(input logic [DATA_W-1:0] data,
                                         input logic [SIZE_W-1:0] size);
        logic fits;
        fits = 1'b1;
        case (size)
            SZ_BYTE: fits = (&data[31:7])  | ~(|data[31:7]);
            SZ_HALF: fits = (&data[31:15]) | ~(|data[31:15]);
            default: fits = 1'b1;
        endcase
        return fits;
    endfunction

endpackage

// File: rtl/store_narrow_unit_if.sv
// CPU request/response and word-memory signals of the narrowing store unit.
// slave: the store unit itself; master: the MEM stage plus data memory around it.
interface store_narrow_unit_if;
    import store_narrow_unit_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [SIZE_W-1:0] req_size;
    logic              resp_valid;
    logic              resp_err;
    logic              resp_ovf;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rd_valid;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_wdata;

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_rdata, mem_rd_valid,
        output req_ready, resp_valid, resp_err, resp_ovf,
               mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_rdata, mem_rd_valid,
        input  req_ready, resp_valid, resp_err, resp_ovf,
               mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );

endinterface

// File: rtl/store_narrow_unit_lane_merge.sv
// Little-endian lane insert: replaces the addressed byte/half of a memory word.
// Purely combinational so a load-extract unit can reuse the same lane mapping.
module store_lane_merge
    import store_narrow_unit_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] wdata,
    input  logic [LANE_W-1:0] lane,
    input  logic [SIZE_W-1:0] size,
    output logic [DATA_W-1:0] merged_c
);

    always_comb begin
        merged_c = rdata;
        case (size)
            SZ_BYTE: merged_c[{lane, 3'b000} +: 8]     = wdata[7:0];
            SZ_HALF: merged_c[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            SZ_WORD: merged_c = wdata;
            default: merged_c = rdata;
        endcase
    end

endmodule

// File: rtl/store_narrow_unit.sv
// Narrowing store unit: byte/half stores via read-modify-write of a word-only memory,
// word stores written directly; flags misalignment, read timeout and signed overflow.
module store_narrow_unit
    import store_narrow_unit_pkg::*;
#(
    parameter int unsigned RD_TIMEOUT = 16,
    parameter int unsigned CNT_W      = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    store_narrow_unit_if.slave bus
);

    state_e            state_q;
    req_t              req_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic [DATA_W-1:0] merged_c;
    logic              acc_err_c;

    store_lane_merge u_merge (
        .rdata    (bus.mem_rdata),
        .wdata    (req_q.data),
        .lane     (req_q.lane),
        .size     (req_q.size),
        .merged_c (merged_c)
    );

    // Illegal size or a size/address alignment clash rejects the request at acceptance.
    always_comb begin
        acc_err_c = 1'b0;
        case (bus.req_size)
            SZ_BYTE: acc_err_c = 1'b0;
            SZ_HALF: acc_err_c = bus.req_addr[0];
            SZ_WORD: acc_err_c = |bus.req_addr[1:0];
            default: acc_err_c = 1'b1;
        endcase
    end

    assign cnt_inc_c = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            req_q          <= '0;
            cnt_q          <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_ovf   <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_rd_en  <= 1'b0;
            bus.mem_wr_en  <= 1'b0;
            bus.mem_wdata  <= '0;
        end else begin
            // Strobes and the response are single-cycle pulses.
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_ovf   <= 1'b0;
            bus.mem_rd_en  <= 1'b0;
            bus.mem_wr_en  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_q         <= '{data: bus.req_data, size: bus.req_size,
                                           lane: bus.req_addr[1:0]};
                        bus.mem_addr  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                        bus.req_ready <= 1'b0;
                        if (acc_err_c) begin
                            state_q        <= ERR;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                        end else if (bus.req_size == SZ_WORD) begin
                            state_q        <= WRITE;
                            bus.mem_wr_en  <= 1'b1;
                            bus.mem_wdata  <= bus.req_data;
                            bus.resp_valid <= 1'b1;
                        end else begin
                            state_q       <= READ;
                            bus.mem_rd_en <= 1'b1;
                        end
                    end
                end

                READ: begin
                    state_q <= WAIT_RD;
                    cnt_q   <= '0;
                end

                // Read data takes priority over a timeout landing in the same cycle.
                WAIT_RD: begin
                    if (bus.mem_rd_valid) begin
                        state_q        <= WRITE;
                        bus.mem_wr_en  <= 1'b1;
                        bus.mem_wdata  <= merged_c;
                        bus.resp_valid <= 1'b1;
                        bus.resp_ovf   <= ~fits_signed(req_q.data, req_q.size);
                    end else begin
                        cnt_q <= cnt_inc_c;
                        if (cnt_inc_c == CNT_W'(RD_TIMEOUT)) begin
                            state_q        <= ERR;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                        end
                    end
                end

                WRITE, ERR: begin
                    state_q       <= IDLE;
                    bus.req_ready <= 1'b1;
                end

                default: begin
                    state_q       <= IDLE;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Directed bench for store_narrow_unit: vector table driven through a cycle-level
// memory model, plus hand sequences for back-to-back requests and mid-read reset.
module tb_store_narrow_unit;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    store_narrow_unit_if bus ();

    store_narrow_unit #(
        .RD_TIMEOUT (16),
        .CNT_W      (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [31:0] rdata;
        int          lat;
        logic        exp_err;
        logic        exp_ovf;
        int          exp_wr;
        int          exp_rd;
        logic [31:0] exp_wdata;
        logic [31:0] exp_addr;
        int          exp_cyc;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and play the memory: rd_valid arrives lat cycles after rd_en (0 = never).
    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        int rd_at;
        int resp_at;
        int wr_n;
        int rd_n;
        int resp_n;
        cyc = 1; rd_at = -1; resp_at = -1; wr_n = 0; rd_n = 0; resp_n = 0;
        chk($sformatf("v%0d_ready_idle", idx), 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = v.addr;
        bus.req_data  = v.data;
        bus.req_size  = v.size;
        bus.mem_rdata = v.rdata;
        tick();
        bus.req_valid = 1'b0;
        while (cyc <= 40 && (resp_at < 0 || cyc <= resp_at + 2)) begin
            chk($sformatf("v%0d_c%0d_strobe_excl", idx, cyc),
                32'(bus.mem_rd_en & bus.mem_wr_en), 32'd0);
            if (bus.mem_rd_en) begin
                rd_n++;
                if (rd_at < 0) rd_at = cyc;
                chk($sformatf("v%0d_rd_addr", idx), bus.mem_addr, v.exp_addr);
            end
            if (bus.mem_wr_en) begin
                wr_n++;
                chk($sformatf("v%0d_wdata", idx), bus.mem_wdata, v.exp_wdata);
                chk($sformatf("v%0d_wr_addr", idx), bus.mem_addr, v.exp_addr);
                chk($sformatf("v%0d_wr_with_resp", idx), 32'(bus.resp_valid), 32'd1);
            end
            if (resp_at < 0 || cyc == resp_at)
                chk($sformatf("v%0d_c%0d_busy", idx, cyc), 32'(bus.req_ready), 32'd0);
            if (resp_at >= 0 && cyc == resp_at + 1)
                chk($sformatf("v%0d_ready_back", idx), 32'(bus.req_ready), 32'd1);
            if (bus.resp_valid) begin
                resp_n++;
                if (resp_at < 0) begin
                    resp_at = cyc;
                    chk($sformatf("v%0d_resp_cyc", idx), 32'(cyc), 32'(v.exp_cyc));
                    chk($sformatf("v%0d_err", idx), 32'(bus.resp_err), 32'(v.exp_err));
                    chk($sformatf("v%0d_ovf", idx), 32'(bus.resp_ovf), 32'(v.exp_ovf));
                end
            end
            bus.mem_rd_valid = (v.lat != 0 && rd_at >= 0 && cyc == rd_at + v.lat);
            tick();
            cyc++;
        end
        bus.mem_rd_valid = 1'b0;
        chk($sformatf("v%0d_resp_seen", idx), 32'(resp_n), 32'd1);
        chk($sformatf("v%0d_wr_count", idx), 32'(wr_n), 32'(v.exp_wr));
        chk($sformatf("v%0d_rd_count", idx), 32'(rd_n), 32'(v.exp_rd));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        //           addr          data          sz     rdata         lat err ovf wr rd wdata         addr          cyc
        vecs[0]  = '{32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 32'h0,        0, 0, 0, 1, 0, 32'hDEAD_BEEF, 32'h0000_0100, 1};
        vecs[1]  = '{32'h0000_0203, 32'hFFFF_FFFA, 2'b00, 32'h1122_3344, 1, 0, 0, 1, 1, 32'hFA22_3344, 32'h0000_0200, 3};
        vecs[2]  = '{32'h0000_0002, 32'h0000_8000, 2'b01, 32'hAAAA_BBBB, 1, 0, 1, 1, 1, 32'h8000_BBBB, 32'h0000_0000, 3};
        vecs[3]  = '{32'h0000_0002, 32'h0000_7FFF, 2'b01, 32'hAAAA_BBBB, 1, 0, 0, 1, 1, 32'h7FFF_BBBB, 32'h0000_0000, 3};
        vecs[4]  = '{32'h0000_0001, 32'h0000_1234, 2'b01, 32'h0,        1, 1, 0, 0, 0, 32'h0,         32'h0,         1};
        vecs[5]  = '{32'h0000_0006, 32'h0000_1234, 2'b10, 32'h0,        1, 1, 0, 0, 0, 32'h0,         32'h0,         1};
        vecs[6]  = '{32'h0000_0008, 32'h0000_0001, 2'b11, 32'h0,        1, 1, 0, 0, 0, 32'h0,         32'h0,         1};
        vecs[7]  = '{32'h0000_0010, 32'h0000_0080, 2'b00, 32'h5566_7788, 3, 0, 1, 1, 1, 32'h5566_7780, 32'h0000_0010, 5};
        vecs[8]  = '{32'h0000_0011, 32'h1234_5601, 2'b00, 32'hA5A5_A5A5, 2, 0, 1, 1, 1, 32'hA5A5_01A5, 32'h0000_0010, 4};
        vecs[9]  = '{32'h0000_0004, 32'hFFFF_8001, 2'b01, 32'h1234_5678, 1, 0, 0, 1, 1, 32'h1234_8001, 32'h0000_0004, 3};
        vecs[10] = '{32'hFFFF_FFFC, 32'h8000_0000, 2'b10, 32'h0,        0, 0, 0, 1, 0, 32'h8000_0000, 32'hFFFF_FFFC, 1};
        vecs[11] = '{32'h0000_0040, 32'h0000_0005, 2'b00, 32'h0,        0, 1, 0, 0, 1, 32'h0,         32'h0000_0040, 18};
        vecs[12] = '{32'h0000_0042, 32'h0000_007F, 2'b00, 32'hFFFF_FFFF, 16, 0, 0, 1, 1, 32'hFF7F_FFFF, 32'h0000_0040, 18};
        vecs[13] = '{32'h0000_0043, 32'h0000_0005, 2'b00, 32'h0,        17, 1, 0, 0, 1, 32'h0,         32'h0000_0040, 18};

        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_addr     = '0;
        bus.req_data     = '0;
        bus.req_size     = '0;
        bus.mem_rdata    = '0;
        bus.mem_rd_valid = 1'b0;
        repeat (3) tick();

        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_resp_ovf", 32'(bus.resp_ovf), 32'd0);
        chk("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
        chk("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_wdata", bus.mem_wdata, 32'h0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], i);
            tick();
        end

        // req_valid held high across a busy cycle: second request taken only once idle.
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0300;
        bus.req_data  = 32'h1111_1111;
        bus.req_size  = 2'b10;
        tick();
        chk("b2b_wr1", 32'(bus.mem_wr_en), 32'd1);
        chk("b2b_wdata1", bus.mem_wdata, 32'h1111_1111);
        chk("b2b_busy", 32'(bus.req_ready), 32'd0);
        bus.req_addr = 32'h0000_0304;
        bus.req_data = 32'h2222_2222;
        tick();
        chk("b2b_gap_wr", 32'(bus.mem_wr_en), 32'd0);
        chk("b2b_gap_resp", 32'(bus.resp_valid), 32'd0);
        chk("b2b_gap_ready", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        chk("b2b_wr2", 32'(bus.mem_wr_en), 32'd1);
        chk("b2b_wdata2", bus.mem_wdata, 32'h2222_2222);
        chk("b2b_addr2", bus.mem_addr, 32'h0000_0304);
        tick();
        chk("b2b_ready_end", 32'(bus.req_ready), 32'd1);
        tick();

        // Reset while waiting for read data aborts silently; late rd_valid is ignored.
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0050;
        bus.req_data  = 32'h0000_0033;
        bus.req_size  = 2'b00;
        bus.mem_rdata = 32'hCAFE_F00D;
        tick();
        bus.req_valid = 1'b0;
        chk("rstmid_rd_en", 32'(bus.mem_rd_en), 32'd1);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rstmid_ready", 32'(bus.req_ready), 32'd1);
        chk("rstmid_addr", bus.mem_addr, 32'h0);
        chk("rstmid_rd_en0", 32'(bus.mem_rd_en), 32'd0);
        bus.mem_rd_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rstmid_wr_%0d", k), 32'(bus.mem_wr_en), 32'd0);
            chk($sformatf("rstmid_resp_%0d", k), 32'(bus.resp_valid), 32'd0);
            chk($sformatf("rstmid_rdy_%0d", k), 32'(bus.req_ready), 32'd1);
        end
        bus.mem_rd_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
